// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with burst hold, default-master parking; define AHB_ARB_LOCK_EN for locked transfers
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MIDX_W         = $clog2(NUM_MASTERS)
) (
    input  logic                   Hclk,
    input  logic                   Hreset,
    input  logic [NUM_MASTERS-1:0] Hreq,
    input  logic [NUM_MASTERS-1:0] Hlock,
    input  logic                   Hready,
    input  logic [1:0]             Htrans,
    input  logic [2:0]             Hburst,
    input  logic [1:0]             Hresp,
    output logic [NUM_MASTERS-1:0] Hgrant,
    output logic [MIDX_W-1:0]      Hmaster,
    output logic                   Hmastlock
);
    typedef enum logic [1:0] {PARK, OWN, BURST} state_t;
    localparam logic [MIDX_W-1:0] DEF = MIDX_W'(DEFAULT_MASTER);
    localparam logic [1:0] T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
    state_t                   r_state, w_state_n;
    logic [NUM_MASTERS-1:0]   r_grant;
    logic [MIDX_W-1:0]        r_gidx, w_gidx_n, r_last, w_last_n, r_master, w_master_n;
    logic [MIDX_W-1:0]        w_win, w_idx;
    logic [3:0]               r_beats, w_beats_n, w_len;
    logic                     r_excl, w_excl_n, r_mastlock, w_mastlock_n, w_found, w_lock, w_unused;
    logic [NUM_MASTERS-1:0]   w_oth, w_req;
`ifdef AHB_ARB_LOCK_EN
    assign w_lock   = Hlock[r_gidx];
    assign w_unused = Hburst[0];
`else
    assign w_lock   = 1'b0;
    assign w_unused = ^{Hlock, Hburst[0]};
`endif
    // INCR (001) falls into the SINGLE bucket, so it re-arbitrates every beat
    assign w_len = (Hburst[2:1] == 2'd0) ? 4'd0 :
                   (Hburst[2:1] == 2'd1) ? 4'd3 :
                   (Hburst[2:1] == 2'd2) ? 4'd7 : 4'd15;
    // After an error the aborted owner only wins if nobody else is asking
    assign w_oth = Hreq & ~r_grant;
    assign w_req = (r_excl && |w_oth) ? w_oth : Hreq;
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        w_idx   = r_last;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_idx = MIDX_W'((int'(r_last) + k) % NUM_MASTERS);
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end
    always_comb begin
        w_state_n    = r_state;
        w_gidx_n     = r_gidx;
        w_last_n     = r_last;
        w_beats_n    = r_beats;
        w_excl_n     = r_excl;
        w_master_n   = r_master;
        w_mastlock_n = r_mastlock;
        if (!Hready) begin
            if (Hresp != 2'b00) begin
                w_beats_n = 4'd0;
                w_state_n = OWN;
                w_excl_n  = 1'b1;
            end
        end else begin
            w_master_n   = r_gidx;
            w_mastlock_n = w_lock;
            if (r_state == BURST) begin
                if (Htrans == T_SEQ) begin
                    w_beats_n = (r_beats == 4'd0) ? 4'd0 : r_beats - 4'd1;
                    w_state_n = (r_beats <= 4'd1) ? OWN : BURST;
                end else if (Htrans != T_BUSY) begin
                    w_beats_n = 4'd0;
                    w_state_n = OWN;
                end
            end else if (Htrans == T_NONSEQ && w_len != 4'd0) begin
                w_beats_n = w_len;
                w_state_n = BURST;
            end else if (w_lock) begin
                w_state_n = OWN;
                w_excl_n  = 1'b0;
            end else if (w_found) begin
                w_gidx_n  = w_win;
                w_last_n  = w_win;
                w_state_n = OWN;
                w_excl_n  = 1'b0;
            end else begin
                w_gidx_n  = DEF;
                w_state_n = PARK;
                w_excl_n  = 1'b0;
            end
        end
    end
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            r_state    <= PARK;
            r_gidx     <= DEF;
            r_grant    <= NUM_MASTERS'(1) << DEF;
            r_last     <= DEF;
            r_beats    <= 4'd0;
            r_excl     <= 1'b0;
            r_master   <= DEF;
            r_mastlock <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_gidx     <= w_gidx_n;
            r_grant    <= NUM_MASTERS'(1) << w_gidx_n;
            r_last     <= w_last_n;
            r_beats    <= w_beats_n;
            r_excl     <= w_excl_n;
            r_master   <= w_master_n;
            r_mastlock <= w_mastlock_n;
        end
    end
    assign Hgrant    = r_grant;
    assign Hmaster   = r_master;
    assign Hmastlock = r_mastlock;
endmodule
